// File: rtl/ram_sync_clear.sv
// Single-port synchronous RAM with byte-lane writes, a registered read with a valid strobe,
// and a clear engine that zeroes every word after reset or on request.
module ram_sync_clear #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    chip_select,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    clear,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_next;
    logic                    in_range;
    logic                    do_write;
    logic                    do_read;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // NOTE: every comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
        endcase
    end

    // A same-cycle clear request has priority and drops the access.
    always_comb begin
        busy     = (state == CLEAR);
        in_range = ({1'b0, address} < DEPTH_EXT);
        do_write = (state == IDLE) && !clear && chip_select && we;
        do_read  = (state == IDLE) && !clear && chip_select && !we;
    end

    // NOTE: the array has no reset; zeroing is done word-by-word by the clear engine instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (busy) begin
                mem[ptr] <= '0;
            end else if (do_write && in_range) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (be[i]) begin
                        mem[address][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_read;
            if (do_read) begin
                data_out <= in_range ? mem[address] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_sync_clear.sv
// Self-checking bench for ram_sync_clear: a default 32-word instance plus a 20-word instance
// for out-of-range addressing, checked against an array model of the memory contents.
module tb_ram_sync_clear;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        cs = 1'b0, we = 1'b0, clear = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [4:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        rd_valid, busy;

    logic        cs2 = 1'b0, we2 = 1'b0, clear2 = 1'b0;
    logic [3:0]  be2 = 4'h0;
    logic [4:0]  address2 = '0;
    logic [31:0] data_in2 = '0;
    logic [31:0] data_out2;
    logic        rd_valid2, busy2;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_mem [32];

    always #5 clock = ~clock;

    ram_sync_clear dut (
        .clock(clock), .reset(reset), .chip_select(cs), .we(we), .be(be),
        .address(address), .data_in(data_in), .clear(clear),
        .data_out(data_out), .rd_valid(rd_valid), .busy(busy)
    );

    ram_sync_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20)) dut20 (
        .clock(clock), .reset(reset), .chip_select(cs2), .we(we2), .be(be2),
        .address(address2), .data_in(data_in2), .clear(clear2),
        .data_out(data_out2), .rd_valid(rd_valid2), .busy(busy2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; we = 1'b0; clear = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (b[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; we = 1'b1; address = a; data_in = d; be = b;
        step();
        idle();
        model_write(a, d, b);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic v);
        cs = 1'b1; we = 1'b0; address = a;
        step();
        d = data_out; v = rd_valid;
        idle();
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        cs2 = 1'b1; we2 = 1'b1; address2 = a; data_in2 = d; be2 = 4'hF;
        step();
        cs2 = 1'b0; we2 = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a, output logic [31:0] d, output logic v);
        cs2 = 1'b1; we2 = 1'b0; address2 = a;
        step();
        d = data_out2; v = rd_valid2;
        cs2 = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        int n20 = -1;
        logic [31:0] d;
        logic v;
        reset = 1'b1; idle();
        step(); step();
        checks++;
        if (busy !== 1'b1 || data_out !== 32'h0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%b data_out=%h rd_valid=%b expected 1/0/0", busy, data_out, rd_valid);
        end
        reset = 1'b0;
        model_zero();
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (busy2 !== 1'b1 && n20 < 0) n20 = n;
            checks++;
            if (data_out !== 32'h0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_clear_outputs cycle=%0d data_out=%h rd_valid=%b expected 0/0", n, data_out, rd_valid);
            end
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL reset_busy_len got=%0d expected=32", n);
        end
        checks++;
        if (n20 != 20) begin
            failures++;
            $display("FAIL reset_busy_len_depth20 got=%0d expected=20", n20);
        end
        rd(5'd7, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL read_after_reset data=%h valid=%b expected 00000000/1", d, v);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid_pulse got=%b expected=0", rd_valid);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic v;
        wr(5'd3, 32'hDEADBEEF, 4'b1111);
        wr(5'd3, 32'h11223344, 4'b0101);
        wr(5'd3, 32'hFFFFFFFF, 4'b0000);
        rd(5'd3, d, v);
        checks++;
        if (d !== 32'hDE22BE44 || v !== 1'b1) begin
            failures++;
            $display("FAIL byte_lanes data=%h valid=%b expected DE22BE44/1", d, v);
        end
        checks++;
        if (d !== model_mem[3]) begin
            failures++;
            $display("FAIL byte_lanes_model data=%h expected=%h", d, model_mem[3]);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL byte_lanes_pulse rd_valid=%b expected=0", rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        wr(5'd0, 32'hA0, 4'hF);
        wr(5'd1, 32'hA1, 4'hF);
        wr(5'd2, 32'hA2, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cs = 1'b1; we = 1'b0; address = 5'(i);
            step();
            exp_d = 32'hA0 + 32'(i);
            checks++;
            if (data_out !== exp_d || rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d] data=%h valid=%b expected %h/1", i, data_out, rd_valid, exp_d);
            end
        end
        idle();
        step();
        checks++;
        if (data_out !== 32'hA2 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_hold data=%h valid=%b expected 000000A2/0", data_out, rd_valid);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        logic [31:0] d;
        logic v;
        wr(5'd9, 32'h55, 4'hF);
        cs = 1'b1; we = 1'b1; address = 5'd9; data_in = 32'h77; be = 4'hF; clear = 1'b1;
        step();
        idle();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_start busy=%b expected=1", busy);
        end
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                clear = 1'b1; cs = 1'b1; we = 1'b0; address = 5'd9;
            end
            step();
            idle();
            n++;
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL clear_no_valid cycle=%0d rd_valid=%b expected=0", n, rd_valid);
            end
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL clear_busy_len got=%0d expected=32", n);
        end
        model_zero();
        rd(5'd9, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL clear_dropped_write data=%h valid=%b expected 00000000/1", d, v);
        end
        rd(5'd3, d, v);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL clear_zeroed data=%h expected=00000000", d);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        logic [31:0] d;
        logic v;
        wr(5'd4, 32'hCAFEF00D, 4'hF);
        rd(5'd4, d, v);
        checks++;
        if (d !== 32'hCAFEF00D || v !== 1'b1) begin
            failures++;
            $display("FAIL pre_clear_read data=%h valid=%b expected CAFEF00D/1", d, v);
        end
        clear = 1'b1;
        step();
        idle();
        for (int i = 0; i < 10; i++) begin
            cs = 1'b1; we = 1'b0; address = 5'($urandom_range(0, 31));
            step();
            checks++;
            if (rd_valid !== 1'b0 || data_out !== 32'hCAFEF00D || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_read_dropped valid=%b data=%h busy=%b expected 0/CAFEF00D/1", rd_valid, data_out, busy);
            end
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (data_out !== 32'h0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_reset data=%h valid=%b busy=%b expected 0/0/1", data_out, rd_valid, busy);
        end
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL restart_busy_len got=%0d expected=32", n);
        end
        model_zero();
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic        exp_v;
        logic [31:0] d;
        logic v;
        logic [4:0]  a;
        rd(5'd0, d, v);
        exp_d = model_mem[0];
        checks++;
        if (d !== exp_d || v !== 1'b1) begin
            failures++;
            $display("FAIL random_seed_read data=%h valid=%b expected %h/1", d, v, exp_d);
        end
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 2);
            a  = 5'($urandom_range(0, 31));
            cs = 1'b0; we = 1'b0;
            if (op == 1) begin
                cs = 1'b1; we = 1'b1; address = a;
                data_in = $urandom; be = 4'($urandom_range(0, 15));
                model_write(a, data_in, be);
                exp_v = 1'b0;
            end else if (op == 2) begin
                cs = 1'b1; we = 1'b0; address = a;
                exp_d = model_mem[a];
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            step();
            checks++;
            if (data_out !== exp_d || rd_valid !== exp_v) begin
                failures++;
                $display("FAIL random[%0d] op=%0d addr=%0d data=%h valid=%b expected %h/%b",
                         i, op, a, data_out, rd_valid, exp_d, exp_v);
            end
        end
        idle();
        step();
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic v;
        int n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (busy2 !== 1'b0) begin
            failures++;
            $display("FAIL oor_idle busy2=%b expected=0", busy2);
        end
        wr2(5'd25, 32'hFFFFFFFF);
        rd2(5'd25, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL oor_read25 data=%h valid=%b expected 00000000/1", d, v);
        end
        rd2(5'd19, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL oor_read19 data=%h valid=%b expected 00000000/1", d, v);
        end
        for (int i = 0; i < 20; i++) begin
            rd2(5'(i), d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b1) begin
                failures++;
                $display("FAIL oor_unchanged[%0d] data=%h valid=%b expected 00000000/1", i, d, v);
            end
        end
        wr2(5'd19, 32'h12345678);
        rd2(5'd19, d, v);
        checks++;
        if (d !== 32'h12345678 || v !== 1'b1) begin
            failures++;
            $display("FAIL last_word data=%h valid=%b expected 12345678/1", d, v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
